// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC scheduler: FSM state encoding,
// default datapath sizes and the channel-id width helper.
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      MAC    = 3'd2,
      DRAIN  = 3'd3,
      OUTPUT = 3'd4
   } fir_state_t;

   localparam int FIR_TAPS        = 32;
   localparam int FIR_DATA_WIDTH  = 8;
   localparam int FIR_ACCUM_WIDTH = 24;

   // A single channel still needs a 1-bit id port.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin channel arbiter: combinational one-hot grant, registered pointer.
// FIR_MAC_SCHED_PRIO_EN gives channel 0 strict priority over the rotation.
module fir_rr_arbiter
   import fir_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NUM_CH-1:0]           i_req,
   input  logic                        i_en,
   output logic [NUM_CH-1:0]           o_grant,
   output logic [ch_width(NUM_CH)-1:0] o_grant_idx
);

   localparam int CH_W = ch_width(NUM_CH);

   logic [CH_W-1:0]   r_ptr;
   logic [CH_W-1:0]   w_idx;
   logic [CH_W-1:0]   w_ptr_nxt;
   logic [NUM_CH-1:0] w_req_rr;
   logic              w_found;
   int                w_pos;

   always_comb begin
      w_req_rr = i_req;
      w_found  = 1'b0;
      w_idx    = '0;
      w_pos    = 0;
`ifdef FIR_MAC_SCHED_PRIO_EN
      // Channel 0 bypasses the rotation entirely.
      w_req_rr[0] = 1'b0;
      if (i_req[0]) begin
         w_found = 1'b1;
      end
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         w_pos = int'(r_ptr) + k;
         if (w_pos >= NUM_CH) begin
            w_pos = w_pos - NUM_CH;
         end
         if (!w_found && w_req_rr[w_pos]) begin
            w_found = 1'b1;
            w_idx   = CH_W'(w_pos);
         end
      end
      o_grant = '0;
      if (i_en && w_found) begin
         o_grant[w_idx] = 1'b1;
      end
   end

   assign w_ptr_nxt   = (int'(w_idx) == NUM_CH - 1) ? '0 : w_idx + CH_W'(1);
   assign o_grant_idx = w_idx;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (|o_grant) begin
`ifdef FIR_MAC_SCHED_PRIO_EN
         if (w_idx != '0) begin
            r_ptr <= w_ptr_nxt;
         end
`else
         r_ptr <= w_ptr_nxt;
`endif
      end
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one FIR MAC datapath across NUM_CH channels: grant, load, TAPS MACs,
// pipeline drain, tagged result. FIR_MAC_SCHED_PRIO_EN selects channel-0 priority.
//
// state  | meaning
// IDLE   | arbitrating; ch_ready is the one-hot grant
// LOAD   | write granted sample to delay line, clear accumulator
// MAC    | TAPS accumulate cycles, tap_addr 0..TAPS-1
// DRAIN  | wait MAC_LAT cycles, capture mac_acc on the last one
// OUTPUT | hold result until out_ready
module fir_mac_scheduler
   import fir_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int TAPS        = FIR_TAPS,
   parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
   parameter int ACCUM_WIDTH = FIR_ACCUM_WIDTH,
   parameter int MAC_LAT     = 1
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NUM_CH-1:0]            i_ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
   output logic [NUM_CH-1:0]            o_ch_ready,
   input  logic                         i_flush,
   output logic                         o_sample_wr,
   output logic [DATA_WIDTH-1:0]        o_sample_data,
   output logic [ch_width(NUM_CH)-1:0]  o_ch_sel,
   output logic [$clog2(TAPS)-1:0]      o_tap_addr,
   output logic                         o_acc_clr,
   output logic                         o_acc_en,
   input  logic [ACCUM_WIDTH-1:0]       i_mac_acc,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [ACCUM_WIDTH-1:0]       o_out_data,
   output logic [ch_width(NUM_CH)-1:0]  o_out_ch,
   output logic                         o_busy
);

   localparam int CH_W = ch_width(NUM_CH);
   localparam int TA_W = $clog2(TAPS);
   localparam logic [TA_W-1:0] LAST_TAP = TA_W'(TAPS - 1);

   fir_state_t        r_state;
   logic [CH_W-1:0]   r_ch_sel;
   logic [DATA_WIDTH-1:0] r_sample_data;
   logic              r_sample_wr;
   logic              r_acc_clr;
   logic              r_acc_en;
   logic [TA_W-1:0]   r_tap_addr;
   logic [2:0]        r_drain_cnt;
   logic              r_out_valid;
   logic [ACCUM_WIDTH-1:0] r_out_data;
   logic [CH_W-1:0]   r_out_ch;
   logic              r_busy;

   logic              w_arb_en;
   logic [NUM_CH-1:0] w_grant;
   logic [CH_W-1:0]   w_grant_idx;
   logic              w_hs;

   assign w_arb_en = (r_state == IDLE) && !i_flush;
   assign w_hs     = |(i_ch_valid & w_grant);

   fir_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_req       (i_ch_valid),
      .i_en        (w_arb_en),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_ch_sel      <= '0;
         r_sample_data <= '0;
         r_sample_wr   <= 1'b0;
         r_acc_clr     <= 1'b0;
         r_acc_en      <= 1'b0;
         r_tap_addr    <= '0;
         r_drain_cnt   <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_ch      <= '0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_state       <= LOAD;
                  r_ch_sel      <= w_grant_idx;
                  r_sample_data <= i_ch_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                  r_sample_wr   <= 1'b1;
                  r_acc_clr     <= 1'b1;
                  r_busy        <= 1'b1;
               end
            end
            LOAD: begin
               r_sample_wr <= 1'b0;
               r_acc_clr   <= 1'b0;
               if (i_flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state    <= MAC;
                  r_acc_en   <= 1'b1;
                  r_tap_addr <= '0;
               end
            end
            MAC: begin
               if (i_flush) begin
                  r_state  <= IDLE;
                  r_acc_en <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (r_tap_addr == LAST_TAP) begin
                  r_acc_en <= 1'b0;
                  // Zero-latency datapath: the sum is already on mac_acc.
                  if (MAC_LAT == 0) begin
                     r_out_data  <= i_mac_acc;
                     r_out_ch    <= r_ch_sel;
                     r_out_valid <= 1'b1;
                     r_state     <= OUTPUT;
                  end else begin
                     r_drain_cnt <= 3'(MAC_LAT - 1);
                     r_state     <= DRAIN;
                  end
               end else begin
                  r_tap_addr <= r_tap_addr + TA_W'(1);
               end
            end
            DRAIN: begin
               if (i_flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_drain_cnt == '0) begin
                  r_out_data  <= i_mac_acc;
                  r_out_ch    <= r_ch_sel;
                  r_out_valid <= 1'b1;
                  r_state     <= OUTPUT;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 3'd1;
               end
            end
            OUTPUT: begin
               if (i_flush || i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ch_ready    = w_grant;
   assign o_sample_wr   = r_sample_wr;
   assign o_sample_data = r_sample_data;
   assign o_ch_sel      = r_ch_sel;
   assign o_tap_addr    = r_tap_addr;
   assign o_acc_clr     = r_acc_clr;
   assign o_acc_en      = r_acc_en;
   assign o_out_valid   = r_out_valid;
   assign o_out_data    = r_out_data;
   assign o_out_ch      = r_out_ch;
   assign o_busy        = r_busy;

endmodule
